seq_control_unit: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle accumulator-CPU decoder. It owns the program counter and instruction register, fetches from instruction ROM with a valid handshake, and stretches LOAD/STORE/ADD/SUB on a RAM ready signal and OUT on a UART ready signal. It also detects a jump-to-self and parks in HALT. It sits between instruction ROM, data RAM, ALU/accumulator and UART TX in the core top level.

---
 rtl/ctrl_pkg.sv | 22 ++
 rtl/program_counter.sv | 23 ++
 rtl/seq_control_unit.sv | 134 +++++++++++++
 tb/tb_seq_control_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the sequencing control unit: opcodes, FSM states, ALU codes.
package ctrl_pkg;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_STORE = 3'b010;
   localparam logic [2:0] OP_ADD   = 3'b011;
   localparam logic [2:0] OP_SUB   = 3'b100;
   localparam logic [2:0] OP_JMP   = 3'b101;
   localparam logic [2:0] OP_JZ    = 3'b110;
   localparam logic [2:0] OP_OUT   = 3'b111;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_HALT  = 2'b10
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment; increment wraps modulo 2^ADDR_W.
module program_counter #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc
);

   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= '0;
      else if (load)
         pc <= load_val;
      else if (inc)
         pc <= pc + 1'b1;
   end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle FETCH/EXEC/HALT sequencer for the accumulator core; strobes are
// decoded combinationally from state, the instruction register and ready inputs.
module seq_control_unit
   import ctrl_pkg::*;
#(
   parameter  int ADDR_W  = 5,
   localparam int INSTR_W = 3 + ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_data,
   input  logic               instr_valid,
   input  logic               zero_flag,
   input  logic               mem_ready,
   input  logic               uart_ready,
   output logic [ADDR_W-1:0]  pc,
   output logic               instr_req,
   output logic [1:0]         alu_op,
   output logic               acc_write,
   output logic               load_sel,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               uart_send,
   output logic               halted
);

   state_t             state, state_next;
   logic [INSTR_W-1:0] ir;
   logic [2:0]         op;
   logic [ADDR_W-1:0]  operand;
   logic               pc_inc, pc_load;

   assign op      = ir[INSTR_W-1:ADDR_W];
   assign operand = ir[ADDR_W-1:0];

   program_counter #(.ADDR_W(ADDR_W)) u_pc (
      .clk      (clk),
      .reset    (reset),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (operand),
      .pc       (pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_FETCH;
         ir    <= '0;
      end else begin
         state <= state_next;
         if (state == ST_FETCH && instr_valid)
            ir <= instr_data;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      instr_req  = 1'b0;
      alu_op     = ALU_ADD;
      acc_write  = 1'b0;
      load_sel   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      uart_send  = 1'b0;
      halted     = 1'b0;

      unique case (state)
         ST_FETCH: begin
            instr_req = 1'b1;
            if (instr_valid)
               state_next = ST_EXEC;
         end

         ST_EXEC: begin
            mem_addr = operand;
            unique case (op)
               OP_NOP: begin
                  pc_inc     = 1'b1;
                  state_next = ST_FETCH;
               end
               OP_LOAD, OP_ADD, OP_SUB: begin
                  mem_read = 1'b1;
                  alu_op   = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                  load_sel = (op == OP_LOAD);
                  if (mem_ready) begin
                     acc_write  = 1'b1;
                     pc_inc     = 1'b1;
                     state_next = ST_FETCH;
                  end
               end
               OP_STORE: begin
                  mem_write = 1'b1;
                  if (mem_ready) begin
                     pc_inc     = 1'b1;
                     state_next = ST_FETCH;
                  end
               end
               OP_OUT: begin
                  if (uart_ready) begin
                     uart_send  = 1'b1;
                     pc_inc     = 1'b1;
                     state_next = ST_FETCH;
                  end
               end
               // A jump to its own address can never make progress, so park.
               OP_JMP: begin
                  if (operand == pc) begin
                     state_next = ST_HALT;
                  end else begin
                     pc_load    = 1'b1;
                     state_next = ST_FETCH;
                  end
               end
               OP_JZ: begin
                  pc_load    = zero_flag;
                  pc_inc     = ~zero_flag;
                  state_next = ST_FETCH;
               end
               default: state_next = ST_FETCH;
            endcase
         end

         ST_HALT: halted = 1'b1;

         default: state_next = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench: directed scenarios plus random stimulus against an
// instruction-level reference model of the control unit.
module tb_seq_control_unit;

   logic       clk;
   logic       reset;
   logic [7:0] instr_data;
   logic       instr_valid;
   logic       zero_flag;
   logic       mem_ready;
   logic       uart_ready;
   logic [4:0] pc;
   logic       instr_req;
   logic [1:0] alu_op;
   logic       acc_write;
   logic       load_sel;
   logic       mem_read;
   logic       mem_write;
   logic [4:0] mem_addr;
   logic       uart_send;
   logic       halted;

   seq_control_unit #(.ADDR_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_data  (instr_data),
      .instr_valid (instr_valid),
      .zero_flag   (zero_flag),
      .mem_ready   (mem_ready),
      .uart_ready  (uart_ready),
      .pc          (pc),
      .instr_req   (instr_req),
      .alu_op      (alu_op),
      .acc_write   (acc_write),
      .load_sel    (load_sel),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .uart_send   (uart_send),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int uart_pulses = 0;

   // Reference model: where the core is in the life of one instruction.
   int m_pc;
   bit m_fetching;
   bit m_parked;
   int m_op;
   int m_opnd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_pc       = 0;
      m_fetching = 1;
      m_parked   = 0;
      m_op       = 0;
      m_opnd     = 0;
   endtask

   task automatic check_outputs();
      bit is_mem_rd, executing;
      executing = !m_fetching && !m_parked;
      is_mem_rd = executing && (m_op == 1 || m_op == 3 || m_op == 4);
      check("pc",        32'(pc),        32'(m_pc));
      check("instr_req", 32'(instr_req), 32'(m_fetching && !m_parked));
      check("halted",    32'(halted),    32'(m_parked));
      check("mem_addr",  32'(mem_addr),  executing ? 32'(m_opnd) : 32'd0);
      check("mem_read",  32'(mem_read),  32'(is_mem_rd));
      check("alu_op",    32'(alu_op),    32'(executing && m_op == 4));
      check("load_sel",  32'(load_sel),  32'(executing && m_op == 1));
      check("acc_write", 32'(acc_write), 32'(is_mem_rd && mem_ready));
      check("mem_write", 32'(mem_write), 32'(executing && m_op == 2));
      check("uart_send", 32'(uart_send), 32'(executing && m_op == 7 && uart_ready));
   endtask

   task automatic model_clock(input logic [7:0] d, input logic v, mr, ur, zf);
      bit done;
      if (m_parked) return;
      if (m_fetching) begin
         if (v) begin
            m_op       = int'(d) / 32;
            m_opnd     = int'(d) % 32;
            m_fetching = 0;
         end
         return;
      end
      case (m_op)
         1, 2, 3, 4: done = mr;
         7:          done = ur;
         default:    done = 1;
      endcase
      if (m_op == 5) begin
         if (m_opnd == m_pc) m_parked = 1;
         else begin m_pc = m_opnd; m_fetching = 1; end
      end else if (m_op == 6) begin
         m_pc = zf ? m_opnd : (m_pc + 1) % 32;
         m_fetching = 1;
      end else if (done) begin
         m_pc = (m_pc + 1) % 32;
         m_fetching = 1;
      end
   endtask

   // One clock cycle: drive, compare mid-cycle, clock the model, return just after the edge.
   task automatic step(input logic [7:0] d, input logic v, mr, ur, zf);
      instr_data  = d;
      instr_valid = v;
      mem_ready   = mr;
      uart_ready  = ur;
      zero_flag   = zf;
      @(negedge clk);
      check_outputs();
      if (uart_send === 1'b1) uart_pulses++;
      @(posedge clk);
      model_clock(d, v, mr, ur, zf);
      #1;
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      mem_ready   = 1'b0;
      uart_ready  = 1'b0;
      zero_flag   = 1'b0;
      reset       = 1'b1;
      #1;
      check("rst_instr_req", 32'(instr_req), 32'd1);
      check("rst_pc",        32'(pc),        32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_alu_op",    32'(alu_op),    32'd0);
      check("rst_halted",    32'(halted),    32'd0);
      check("rst_strobes",   32'({acc_write, load_sel, mem_read, mem_write, uart_send}), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_data  = '0;
      instr_valid = 1'b0;
      zero_flag   = 1'b0;
      mem_ready   = 1'b0;
      uart_ready  = 1'b0;
      reset       = 1'b0;
      model_reset();
      #2;
      do_reset();

      // NOP: FETCH, EXEC, then pc=1 in the third cycle
      step(8'h00, 1, 1, 1, 0);
      step(8'h00, 1, 1, 1, 0);
      check("nop_pc", 32'(pc), 32'd1);
      step(8'h00, 0, 0, 0, 0);

      // LOAD 5 with three wait cycles
      do_reset();
      step(8'h25, 1, 0, 0, 0);
      repeat (3) step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 1, 0, 0);
      check("load_pc", 32'(pc), 32'd1);

      // JZ taken and not taken
      step(8'hCA, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 1);
      check("jz_taken_pc", 32'(pc), 32'd10);
      step(8'hCA, 1, 0, 0, 1);
      step(8'h00, 0, 0, 0, 0);
      check("jz_fall_pc", 32'(pc), 32'd11);

      // JMP 7 then JMP 3
      step(8'hA7, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'hA3, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      check("jmp_pc", 32'(pc), 32'd3);

      // OUT with two uart stalls
      uart_pulses = 0;
      step(8'hE0, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 1, 0);
      check("out_pulses", 32'(uart_pulses), 32'd1);
      check("out_pc", 32'(pc), 32'd4);

      // ADD at pc=31 wraps to 0, then JMP to self halts
      step(8'hBF, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h7F, 1, 0, 0, 0);
      step(8'h00, 0, 1, 0, 0);
      check("wrap_pc", 32'(pc), 32'd0);
      step(8'hA0, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      repeat (3) step(8'h00, 1, 1, 1, 1);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_pc", 32'(pc), 32'd0);

      // Reset in the middle of a STORE wait
      do_reset();
      step(8'h45, 1, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
      do_reset();
      step(8'h00, 1, 1, 1, 0);
      step(8'h00, 0, 0, 0, 0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (m_parked && $urandom_range(0, 3) == 0)
            do_reset();
         else
            step(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
